id_stage: RTL and testbench

- Decode stage of the 5-stage MIPS pipeline, directly downstream of instruction fetch.
- Consumes the fetched instruction word and its PC, and reads the 32x32 register file, which lives here and is written by WB.
- Resolves beq/j/jal/jr in decode, with one branch delay slot, and drives the next-PC back to fetch.
- Holds the D/E pipeline register and inserts a bubble into it on stall.

---
 rtl/id_stage_if.sv | 34 +++
 rtl/id_stage.sv | 116 +++++++++++
 tb/tb_id_stage.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/id_stage_if.sv
// Decode-stage port bundle: fetch-side inputs, forwarding/writeback taps, next-PC and D/E outputs.
interface id_stage_if;
  logic [31:0] F_instruc;
  logic [31:0] FD_PC;
  logic [31:0] F_PC;
  logic        stall;
  logic        M_fwd_en;
  logic [4:0]  M_fwd_addr;
  logic [31:0] M_fwd_data;
  logic        W_we;
  logic [4:0]  W_addr;
  logic [31:0] W_data;
  logic [31:0] F_NPC;
  logic [31:0] DE_instruc;
  logic [31:0] DE_PC;
  logic [31:0] DE_rs_val;
  logic [31:0] DE_rt_val;
  logic [31:0] DE_imm32;
  logic [4:0]  DE_dst;

  modport slave (
    input  F_instruc, FD_PC, F_PC, stall,
    input  M_fwd_en, M_fwd_addr, M_fwd_data,
    input  W_we, W_addr, W_data,
    output F_NPC, DE_instruc, DE_PC, DE_rs_val, DE_rt_val, DE_imm32, DE_dst
  );

  modport master (
    output F_instruc, FD_PC, F_PC, stall,
    output M_fwd_en, M_fwd_addr, M_fwd_data,
    output W_we, W_addr, W_data,
    input  F_NPC, DE_instruc, DE_PC, DE_rs_val, DE_rt_val, DE_imm32, DE_dst
  );
endinterface

// File: rtl/id_stage.sv
// MIPS decode stage: register file, operand forwarding, branch/jump resolution
// with one delay slot, and the D/E pipeline register.
module id_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000,
  parameter int          NREG     = 32
) (
  input  logic        clk,
  input  logic        reset,
  id_stage_if.slave   bus
);
  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] rs_val;
    logic [31:0] rt_val;
    logic [31:0] imm;
    logic [4:0]  dst;
  } de_t;

  localparam logic [5:0] OP_R = 6'h00, OP_J = 6'h02, OP_JAL = 6'h03, OP_BEQ = 6'h04,
                         OP_ORI = 6'h0d, OP_LUI = 6'h0f, OP_LW = 6'h23, OP_SW = 6'h2b;
  localparam logic [5:0] FN_JR = 6'h08, FN_ADDU = 6'h21, FN_SUBU = 6'h23;

  logic [31:0] rf [NREG];
  de_t         de_q, d;
  logic [31:0] rs_v, rt_v, npc, sext;

  logic [31:0] instr;
  logic [5:0]  op, funct;
  logic [4:0]  rs, rt, rd;
  logic [15:0] imm16;

  assign instr = bus.F_instruc;
  assign op    = instr[31:26];
  assign rs    = instr[25:21];
  assign rt    = instr[20:16];
  assign rd    = instr[15:11];
  assign funct = instr[5:0];
  assign imm16 = instr[15:0];
  assign sext  = {{16{imm16[15]}}, imm16};

  // M result is younger than WB, so it wins when both target the same register.
  function automatic logic [31:0] opnd(
    input logic [4:0] a, input logic [31:0] rfv,
    input logic men, input logic [4:0] ma, input logic [31:0] md,
    input logic we, input logic [4:0] wa, input logic [31:0] wd);
    if (a == 5'd0)             return 32'd0;
    else if (men && ma == a)   return md;
    else if (we && wa == a)    return wd;
    else                       return rfv;
  endfunction

  assign rs_v = opnd(rs, rf[rs], bus.M_fwd_en, bus.M_fwd_addr, bus.M_fwd_data,
                     bus.W_we, bus.W_addr, bus.W_data);
  assign rt_v = opnd(rt, rf[rt], bus.M_fwd_en, bus.M_fwd_addr, bus.M_fwd_data,
                     bus.W_we, bus.W_addr, bus.W_data);

  always_comb begin
    d        = '0;
    d.instr  = instr;
    d.pc     = bus.FD_PC;
    d.rs_val = rs_v;
    d.rt_val = rt_v;
    npc      = bus.F_PC + 32'd4;
    case (op)
      OP_R: begin
        case (funct)
          FN_ADDU, FN_SUBU: d.dst = rd;
          FN_JR:            npc   = rs_v;
          default: ;
        endcase
      end
      OP_ORI: begin d.imm = {16'd0, imm16}; d.dst = rt; end
      OP_LUI: begin d.imm = {imm16, 16'd0}; d.dst = rt; end
      OP_LW:  begin d.imm = sext;           d.dst = rt; end
      OP_SW:  d.imm = sext;
      OP_BEQ: begin
        d.imm = sext;
        if (rs_v == rt_v) npc = bus.FD_PC + 32'd4 + {sext[29:0], 2'b00};
      end
      OP_J:   npc = {bus.FD_PC[31:28], instr[25:0], 2'b00};
      OP_JAL: begin
        npc      = {bus.FD_PC[31:28], instr[25:0], 2'b00};
        d.dst    = 5'd31;
        d.rs_val = bus.FD_PC + 32'd8;  // link value rides the rs operand into E
        d.rt_val = 32'd0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NREG; i++) rf[i] <= 32'd0;
    end else if (bus.W_we && bus.W_addr != 5'd0) begin
      rf[bus.W_addr] <= bus.W_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset || bus.stall) de_q <= '0;
    else                    de_q <= d;
  end

  assign bus.F_NPC      = npc;
  assign bus.DE_instruc = de_q.instr;
  assign bus.DE_PC      = de_q.pc;
  assign bus.DE_rs_val  = de_q.rs_val;
  assign bus.DE_rt_val  = de_q.rt_val;
  assign bus.DE_imm32   = de_q.imm;
  assign bus.DE_dst     = de_q.dst;

  // Shift amount is not decoded; the start-up PC is owned by fetch.
  logic unused_ok;
  assign unused_ok = ^{instr[10:6], RESET_PC};
endmodule

// File: tb/tb_id_stage.sv
// Scoreboard bench for id_stage: expected D/E contents queued at drive time,
// popped after the capturing edge; next-PC checked combinationally.
module tb_id_stage;
  logic clk = 1'b0;
  logic reset;
  id_stage_if bus();

  id_stage dut (.clk(clk), .reset(reset), .bus(bus));

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] instr, pc, rs, rt, imm;
    logic [4:0]  dst;
  } de_t;

  de_t sb[$];
  de_t got, exp_de;
  int  total = 0, bad = 0;

  assign got = {bus.DE_instruc, bus.DE_PC, bus.DE_rs_val, bus.DE_rt_val, bus.DE_imm32, bus.DE_dst};

  function automatic logic [31:0] r_op(input logic [4:0] rs, rt, rd, input logic [5:0] fn);
    return {6'd0, rs, rt, rd, 5'd0, fn};
  endfunction
  function automatic logic [31:0] i_op(input logic [5:0] op, input logic [4:0] rs, rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction
  function automatic logic [31:0] j_op(input logic [5:0] op, input logic [25:0] idx);
    return {op, idx};
  endfunction
  function automatic de_t mk(input logic [31:0] instr, pc, rs, rt, imm, input logic [4:0] dst);
    return {instr, pc, rs, rt, imm, dst};
  endfunction

  task automatic idle();
    bus.F_instruc = 32'd0; bus.FD_PC = 32'h3000; bus.F_PC = 32'h3004; bus.stall = 1'b0;
    bus.M_fwd_en = 1'b0; bus.M_fwd_addr = 5'd0; bus.M_fwd_data = 32'd0;
    bus.W_we = 1'b0; bus.W_addr = 5'd0; bus.W_data = 32'd0;
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    idle(); reset = 1'b1;
    bus.F_instruc = r_op(5'd5, 5'd0, 5'd1, 6'h21);
    sb.push_back('0);
    tick(); exp_de = sb.pop_front(); total++;
    if (got !== exp_de) begin bad++; $display("FAIL reset_de: got %h exp %h", got, exp_de); end
    // write $5 via WB (bypassed into the addu), then reset mid-operation with stall also high
    reset = 1'b0; bus.W_we = 1'b1; bus.W_addr = 5'd5; bus.W_data = 32'hAAAA;
    sb.push_back(mk(bus.F_instruc, 32'h3000, 32'hAAAA, 0, 0, 5'd1));
    tick(); exp_de = sb.pop_front(); total++;
    if (got !== exp_de) begin bad++; $display("FAIL pre_reset_bypass: got %h exp %h", got, exp_de); end
    reset = 1'b1; bus.stall = 1'b1; bus.W_we = 1'b0;
    sb.push_back('0);
    tick(); exp_de = sb.pop_front(); total++;
    if (got !== exp_de) begin bad++; $display("FAIL reset_with_stall: got %h exp %h", got, exp_de); end
    reset = 1'b0; bus.stall = 1'b0; bus.F_PC = 32'h3000; #1;
    total++;
    if (bus.F_NPC !== 32'h3004) begin bad++; $display("FAIL reset_npc: got %h exp %h", bus.F_NPC, 32'h3004); end
    sb.push_back(mk(bus.F_instruc, 32'h3000, 0, 0, 0, 5'd1));
    tick(); exp_de = sb.pop_front(); total++;
    if (got !== exp_de) begin bad++; $display("FAIL reg5_cleared: got %h exp %h", got, exp_de); end
  endtask

  task automatic test_bypass();
    idle(); bus.FD_PC = 32'h3004;
    bus.F_instruc = r_op(5'd8, 5'd0, 5'd3, 6'h21);
    bus.W_we = 1'b1; bus.W_addr = 5'd8; bus.W_data = 32'h1234;
    sb.push_back(mk(bus.F_instruc, 32'h3004, 32'h1234, 0, 0, 5'd3));
    tick(); exp_de = sb.pop_front(); total++;
    if (got !== exp_de) begin bad++; $display("FAIL w_bypass: got %h exp %h", got, exp_de); end
    bus.M_fwd_en = 1'b1; bus.M_fwd_addr = 5'd8; bus.M_fwd_data = 32'h55;
    sb.push_back(mk(bus.F_instruc, 32'h3004, 32'h55, 0, 0, 5'd3));
    tick(); exp_de = sb.pop_front(); total++;
    if (got !== exp_de) begin bad++; $display("FAIL m_over_w: got %h exp %h", got, exp_de); end
    idle(); bus.F_instruc = r_op(5'd0, 5'd8, 5'd4, 6'h21);
    sb.push_back(mk(bus.F_instruc, 32'h3000, 0, 32'h1234, 0, 5'd4));
    tick(); exp_de = sb.pop_front(); total++;
    if (got !== exp_de) begin bad++; $display("FAIL rf_read: got %h exp %h", got, exp_de); end
    bus.F_instruc = r_op(5'd8, 5'd8, 5'd6, 6'h23);
    bus.M_fwd_en = 1'b1; bus.M_fwd_addr = 5'd8; bus.M_fwd_data = 32'h77;
    sb.push_back(mk(bus.F_instruc, 32'h3000, 32'h77, 32'h77, 0, 5'd6));
    tick(); exp_de = sb.pop_front(); total++;
    if (got !== exp_de) begin bad++; $display("FAIL subu_m_fwd: got %h exp %h", got, exp_de); end
  endtask

  task automatic test_zero_reg();
    idle(); bus.F_instruc = i_op(6'h0d, 5'd0, 5'd0, 16'h0001);
    bus.W_we = 1'b1; bus.W_addr = 5'd0; bus.W_data = 32'hFFFF;
    sb.push_back(mk(bus.F_instruc, 32'h3000, 0, 0, 32'h1, 5'd0));
    tick(); exp_de = sb.pop_front(); total++;
    if (got !== exp_de) begin bad++; $display("FAIL ori_zero: got %h exp %h", got, exp_de); end
    idle(); bus.F_instruc = r_op(5'd0, 5'd0, 5'd2, 6'h21);
    bus.M_fwd_en = 1'b1; bus.M_fwd_addr = 5'd0; bus.M_fwd_data = 32'h99;
    sb.push_back(mk(bus.F_instruc, 32'h3000, 0, 0, 0, 5'd2));
    tick(); exp_de = sb.pop_front(); total++;
    if (got !== exp_de) begin bad++; $display("FAIL zero_no_fwd: got %h exp %h", got, exp_de); end
  endtask

  task automatic test_branch();
    idle(); bus.FD_PC = 32'h300C; bus.W_we = 1'b1; bus.W_addr = 5'd1; bus.W_data = 32'd7;
    sb.push_back(mk(32'd0, 32'h300C, 0, 0, 0, 5'd0));
    tick(); exp_de = sb.pop_front(); total++;
    if (got !== exp_de) begin bad++; $display("FAIL nop: got %h exp %h", got, exp_de); end
    bus.F_instruc = i_op(6'h04, 5'd1, 5'd2, 16'hFFFE); bus.FD_PC = 32'h3010; bus.F_PC = 32'h3014;
    bus.W_addr = 5'd2; #1;
    total++;
    if (bus.F_NPC !== 32'h300C) begin bad++; $display("FAIL beq_taken_npc: got %h exp %h", bus.F_NPC, 32'h300C); end
    sb.push_back(mk(bus.F_instruc, 32'h3010, 7, 7, 32'hFFFF_FFFE, 5'd0));
    tick(); exp_de = sb.pop_front(); total++;
    if (got !== exp_de) begin bad++; $display("FAIL beq_de: got %h exp %h", got, exp_de); end
    bus.W_we = 1'b0; bus.F_instruc = i_op(6'h04, 5'd1, 5'd3, 16'hFFFE); #1;
    total++;
    if (bus.F_NPC !== 32'h3018) begin bad++; $display("FAIL beq_not_taken_npc: got %h exp %h", bus.F_NPC, 32'h3018); end
    sb.push_back(mk(bus.F_instruc, 32'h3010, 7, 0, 32'hFFFF_FFFE, 5'd0));
    tick(); exp_de = sb.pop_front(); total++;
    if (got !== exp_de) begin bad++; $display("FAIL beq_nt_de: got %h exp %h", got, exp_de); end
    bus.F_instruc = i_op(6'h04, 5'd1, 5'd2, 16'h0003); bus.FD_PC = 32'h3020; bus.F_PC = 32'h3024; #1;
    total++;
    if (bus.F_NPC !== 32'h3030) begin bad++; $display("FAIL beq_fwd_npc: got %h exp %h", bus.F_NPC, 32'h3030); end
    tick();
  endtask

  task automatic test_jumps();
    idle(); bus.F_instruc = j_op(6'h03, 26'h0C04); bus.FD_PC = 32'h3000; bus.F_PC = 32'h3004; #1;
    total++;
    if (bus.F_NPC !== 32'h3010) begin bad++; $display("FAIL jal_npc: got %h exp %h", bus.F_NPC, 32'h3010); end
    sb.push_back(mk(bus.F_instruc, 32'h3000, 32'h3008, 0, 0, 5'd31));
    tick(); exp_de = sb.pop_front(); total++;
    if (got !== exp_de) begin bad++; $display("FAIL jal_de: got %h exp %h", got, exp_de); end
    idle(); bus.F_instruc = r_op(5'd9, 5'd0, 5'd0, 6'h08);
    bus.M_fwd_en = 1'b1; bus.M_fwd_addr = 5'd9; bus.M_fwd_data = 32'h3040; #1;
    total++;
    if (bus.F_NPC !== 32'h3040) begin bad++; $display("FAIL jr_npc: got %h exp %h", bus.F_NPC, 32'h3040); end
    sb.push_back(mk(bus.F_instruc, 32'h3000, 32'h3040, 0, 0, 5'd0));
    tick(); exp_de = sb.pop_front(); total++;
    if (got !== exp_de) begin bad++; $display("FAIL jr_de: got %h exp %h", got, exp_de); end
    idle(); bus.F_instruc = j_op(6'h02, 26'h0100); bus.FD_PC = 32'h7000_0010; #1;
    total++;
    if (bus.F_NPC !== 32'h7000_0400) begin bad++; $display("FAIL j_npc: got %h exp %h", bus.F_NPC, 32'h7000_0400); end
    sb.push_back(mk(bus.F_instruc, 32'h7000_0010, 0, 0, 0, 5'd0));
    tick(); exp_de = sb.pop_front(); total++;
    if (got !== exp_de) begin bad++; $display("FAIL j_de: got %h exp %h", got, exp_de); end
  endtask

  task automatic test_decode();
    idle(); bus.F_instruc = i_op(6'h0f, 5'd0, 5'd7, 16'h8001);
    sb.push_back(mk(bus.F_instruc, 32'h3000, 0, 0, 32'h8001_0000, 5'd7));
    tick(); exp_de = sb.pop_front(); total++;
    if (got !== exp_de) begin bad++; $display("FAIL lui: got %h exp %h", got, exp_de); end
    bus.F_instruc = i_op(6'h2b, 5'd1, 5'd7, 16'hFFFC);
    bus.W_we = 1'b1; bus.W_addr = 5'd7; bus.W_data = 32'hCAFE;
    sb.push_back(mk(bus.F_instruc, 32'h3000, 7, 32'hCAFE, 32'hFFFF_FFFC, 5'd0));
    tick(); exp_de = sb.pop_front(); total++;
    if (got !== exp_de) begin bad++; $display("FAIL sw: got %h exp %h", got, exp_de); end
    idle(); bus.F_instruc = i_op(6'h0d, 5'd1, 5'd9, 16'h8000);
    sb.push_back(mk(bus.F_instruc, 32'h3000, 7, 0, 32'h0000_8000, 5'd9));
    tick(); exp_de = sb.pop_front(); total++;
    if (got !== exp_de) begin bad++; $display("FAIL ori_zext: got %h exp %h", got, exp_de); end
    bus.F_instruc = i_op(6'h08, 5'd1, 5'd5, 16'h0005); bus.F_PC = 32'h3100; #1;
    total++;
    if (bus.F_NPC !== 32'h3104) begin bad++; $display("FAIL illegal_npc: got %h exp %h", bus.F_NPC, 32'h3104); end
    sb.push_back(mk(bus.F_instruc, 32'h3000, 7, 0, 0, 5'd0));
    tick(); exp_de = sb.pop_front(); total++;
    if (got !== exp_de) begin bad++; $display("FAIL illegal_op: got %h exp %h", got, exp_de); end
    bus.F_instruc = r_op(5'd1, 5'd7, 5'd3, 6'h20);
    sb.push_back(mk(bus.F_instruc, 32'h3000, 7, 32'hCAFE, 0, 5'd0));
    tick(); exp_de = sb.pop_front(); total++;
    if (got !== exp_de) begin bad++; $display("FAIL illegal_funct: got %h exp %h", got, exp_de); end
  endtask

  task automatic test_stall();
    idle(); bus.F_instruc = i_op(6'h23, 5'd1, 5'd10, 16'h8000);
    bus.FD_PC = 32'h3040; bus.F_PC = 32'h3044; bus.stall = 1'b1; #1;
    total++;
    if (bus.F_NPC !== 32'h3048) begin bad++; $display("FAIL stall_npc: got %h exp %h", bus.F_NPC, 32'h3048); end
    for (int k = 0; k < 2; k++) begin
      sb.push_back('0);
      tick(); exp_de = sb.pop_front(); total++;
      if (got !== exp_de) begin bad++; $display("FAIL stall_bubble%0d: got %h exp %h", k, got, exp_de); end
    end
    bus.stall = 1'b0;
    sb.push_back(mk(bus.F_instruc, 32'h3040, 7, 0, 32'hFFFF_8000, 5'd10));
    tick(); exp_de = sb.pop_front(); total++;
    if (got !== exp_de) begin bad++; $display("FAIL stall_release_lw: got %h exp %h", got, exp_de); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] vals [8];
    idle();
    for (int i = 0; i < 8; i++) begin
      vals[i] = $urandom;
      bus.F_instruc = r_op((i == 0) ? 5'd0 : 5'(15 + i), 5'(16 + i), 5'(i + 1), (i % 2) ? 6'h23 : 6'h21);
      bus.FD_PC = 32'h4000 + 32'(4 * i);
      bus.W_we = 1'b1; bus.W_addr = 5'(16 + i); bus.W_data = vals[i];
      sb.push_back(mk(bus.F_instruc, 32'h4000 + 32'(4 * i), (i == 0) ? 32'd0 : vals[i-1], vals[i], 0, 5'(i + 1)));
      tick(); exp_de = sb.pop_front(); total++;
      if (got !== exp_de) begin bad++; $display("FAIL b2b_%0d: got %h exp %h", i, got, exp_de); end
    end
  endtask

  initial begin
    test_reset();
    test_bypass();
    test_zero_reg();
    test_branch();
    test_jumps();
    test_decode();
    test_stall();
    test_back_to_back();
    total++;
    if (sb.size() != 0) begin bad++; $display("FAIL scoreboard_leftover: got %0d exp 0", sb.size()); end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
